// File: rtl/mioc_zline_filter.sv
// mioc_zline_filter: synchronise, deglitch and edge-detect the open-drain z line, counting falls.
// Optional sticky fall interrupt (irq/irq_clr) when MIOC_ZFILT_IRQ_EN is defined.
module mioc_zline_filter #(
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z,
  input  logic             cnt_clr,
`ifdef MIOC_ZFILT_IRQ_EN
  input  logic             irq_clr,
  output logic             irq,
`endif
  output logic             z_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             glitch,
  output logic [CNT_W-1:0] fall_cnt
);
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam logic [FW-1:0] LAST = FW'(FILT_CYCLES - 1);
  typedef enum logic [1:0] {HIGH, FALL_PEND, LOW, RISE_PEND} state_t;
  state_t state;
  logic [FW-1:0] filt_cnt;
  logic z_meta, z_sync;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_meta     <= 1'b1;
      z_sync     <= 1'b1;
      z_filt     <= 1'b1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch     <= 1'b0;
      state      <= HIGH;
      filt_cnt   <= '0;
    end else begin
      z_meta     <= z;
      z_sync     <= z_meta;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch     <= 1'b0;
      unique case (state)
        HIGH: if (!z_sync) begin
          state    <= FALL_PEND;
          filt_cnt <= '0;
        end
        FALL_PEND: if (z_sync) begin
          state    <= HIGH;
          glitch   <= 1'b1;
          filt_cnt <= '0;
        end else if (filt_cnt == LAST) begin
          state      <= LOW;
          z_filt     <= 1'b0;
          fall_pulse <= 1'b1;
          filt_cnt   <= '0;
        end else filt_cnt <= filt_cnt + 1'b1;
        LOW: if (z_sync) begin
          state    <= RISE_PEND;
          filt_cnt <= '0;
        end
        RISE_PEND: if (!z_sync) begin
          state    <= LOW;
          glitch   <= 1'b1;
          filt_cnt <= '0;
        end else if (filt_cnt == LAST) begin
          state      <= HIGH;
          z_filt     <= 1'b1;
          rise_pulse <= 1'b1;
          filt_cnt   <= '0;
        end else filt_cnt <= filt_cnt + 1'b1;
      endcase
    end
  end
  // clear takes effect first, so a coincident fall still lands as a count of one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fall_cnt <= '0;
    else if (cnt_clr) fall_cnt <= CNT_W'(fall_pulse);
    else if (fall_pulse && fall_cnt != '1) fall_cnt <= fall_cnt + 1'b1;
  end
`ifdef MIOC_ZFILT_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else if (fall_pulse) irq <= 1'b1;
    else if (irq_clr) irq <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_mioc_zline_filter.sv
// tb_mioc_zline_filter: directed checks of sync latency, deglitch, pulses, counter and reset.
// Runs with CNT_W=4 so saturation is reachable; irq checks compile in with MIOC_ZFILT_IRQ_EN.
module tb_mioc_zline_filter;
  logic clk = 1'b0;
  logic rst_n, z, cnt_clr, irq_clr;
  logic z_filt, rise_pulse, fall_pulse, glitch;
  logic [3:0] fall_cnt;
`ifdef MIOC_ZFILT_IRQ_EN
  logic irq;
`endif
  int checks = 0;
  int failures = 0;

  mioc_zline_filter #(.FILT_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .z(z), .cnt_clr(cnt_clr),
`ifdef MIOC_ZFILT_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .z_filt(z_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .glitch(glitch), .fall_cnt(fall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
`ifdef MIOC_ZFILT_IRQ_EN
    chk(tag, 32'(irq), 32'(exp));
`endif
  endtask

  initial begin
    rst_n = 1'b0; z = 1'b0; cnt_clr = 1'b0; irq_clr = 1'b0;
    cyc(2);
    chk("rst_z_filt", 32'(z_filt), 1);
    chk("rst_rise", 32'(rise_pulse), 0);
    chk("rst_fall", 32'(fall_pulse), 0);
    chk("rst_glitch", 32'(glitch), 0);
    chk("rst_cnt", 32'(fall_cnt), 0);
    chk_irq("rst_irq", 1'b0);
    // release with z held low: fall commits on edge 7
    rst_n = 1'b1;
    cyc(6);
    chk("rel_e6_z_filt", 32'(z_filt), 1);
    cyc(1);
    chk("rel_e7_z_filt", 32'(z_filt), 0);
    chk("rel_e7_fall", 32'(fall_pulse), 1);
    cyc(1);
    chk("rel_e8_fall", 32'(fall_pulse), 0);
    chk("rel_cnt", 32'(fall_cnt), 1);
    chk_irq("irq_set", 1'b1);
    // rise
    z = 1'b1;
    cyc(6);
    chk("rise_e6_z_filt", 32'(z_filt), 0);
    cyc(1);
    chk("rise_e7_z_filt", 32'(z_filt), 1);
    chk("rise_e7_pulse", 32'(rise_pulse), 1);
    cyc(1);
    chk("rise_e8_pulse", 32'(rise_pulse), 0);
    chk("rise_cnt", 32'(fall_cnt), 1);
    chk_irq("irq_sticky", 1'b1);
    irq_clr = 1'b1;
    cyc(1);
    irq_clr = 1'b0;
    chk_irq("irq_clr", 1'b0);
    // glitch: low for 3 sampled cycles aborts on edge 6
    z = 1'b0;
    cyc(3);
    z = 1'b1;
    cyc(2);
    chk("gl_e5", 32'(glitch), 0);
    cyc(1);
    chk("gl_e6", 32'(glitch), 1);
    chk("gl_z_filt", 32'(z_filt), 1);
    cyc(1);
    chk("gl_e7", 32'(glitch), 0);
    cyc(5);
    chk("gl_z_filt_hold", 32'(z_filt), 1);
    chk("gl_cnt", 32'(fall_cnt), 1);
    // low long enough to commit; clear coincident with fall_pulse
    z = 1'b0;
    cyc(5);
    z = 1'b1;
    cyc(1);
    chk("c5_e6_z_filt", 32'(z_filt), 1);
    cyc(1);
    chk("c5_e7_z_filt", 32'(z_filt), 0);
    chk("c5_e7_fall", 32'(fall_pulse), 1);
    cnt_clr = 1'b1;
    irq_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    irq_clr = 1'b0;
    chk("clr_coinc_cnt", 32'(fall_cnt), 1);
    chk_irq("irq_set_wins", 1'b1);
    cyc(10);
    chk("c5_back_high", 32'(z_filt), 1);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr_alone", 32'(fall_cnt), 0);
    // saturation at 15 with CNT_W=4
    for (int i = 0; i < 17; i++) begin
      z = 1'b0;
      cyc(8);
      z = 1'b1;
      cyc(8);
      if (i == 14) chk("sat_15th", 32'(fall_cnt), 15);
    end
    chk("sat_hold", 32'(fall_cnt), 15);
    chk("sat_z_filt", 32'(z_filt), 1);
    // reset while in FALL_PEND with filt_cnt=2
    z = 1'b0;
    cyc(5);
    rst_n = 1'b0;
    cyc(2);
    chk("mid_rst_z_filt", 32'(z_filt), 1);
    chk("mid_rst_cnt", 32'(fall_cnt), 0);
    chk("mid_rst_fall", 32'(fall_pulse), 0);
    chk("mid_rst_glitch", 32'(glitch), 0);
    chk_irq("mid_rst_irq", 1'b0);
    rst_n = 1'b1;
    cyc(6);
    chk("mid_e6_z_filt", 32'(z_filt), 1);
    cyc(1);
    chk("mid_e7_z_filt", 32'(z_filt), 0);
    chk("mid_e7_fall", 32'(fall_pulse), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
